// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
//   DIV_WIDTH   : default operand/result width
//   DIV_CNT_W   : iteration counter width for the default width
//   div_state_e : controller states
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;
endpackage

// File: rtl/seq_signed_divider_step.sv
// div_step: one combinational restoring-division step.
//   rem_i     : partial remainder before the shift (always < div_i)
//   dvd_bit_i : next dividend bit shifted into the remainder
//   div_i     : divisor magnitude (unsigned)
//   rem_o     : partial remainder after the step
//   q_o       : quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem_i < div_i <= 2^(WIDTH-1), so the shifted value always fits in
  // WIDTH bits; the extra bit only carries the borrow of the trial.
  assign shifted = {rem_i, dvd_bit_i};
  assign trial   = shifted - {1'b0, div_i};
  assign q_o     = ~trial[WIDTH];
  assign rem_o   = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: truncating signed divider, one restoring step per
// cycle, start/busy/done handshake.
//   clk, reset : clock, synchronous active-high reset
//   start      : request, sampled only in IDLE
//   A, B       : dividend, divisor (two's complement)
//   busy       : high in CALC and FIX
//   done       : one-cycle result pulse
//   Q, R       : quotient / remainder, held until the next done
//   DZ, OVF    : divide-by-zero / most-negative-by-minus-one flags
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DZ,
  output logic             OVF
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;       // raw dividend, returned as R on /0
  logic [WIDTH-1:0] divm_q, divm_d; // |B|
  logic [WIDTH-1:0] dvd_q, dvd_d;   // |A| shifting out, quotient shifting in
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             sgnq_q, sgnq_d, sgnr_q, sgnr_d;
  logic             dz_q, dz_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] qo_q, qo_d, ro_q, ro_d;
  logic             dzo_q, dzo_d, ovfo_q, ovfo_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[WIDTH-1]),
    .div_i     (divm_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    divm_d  = divm_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    qo_d    = qo_q;
    ro_d    = ro_q;
    dzo_d   = dzo_q;
    ovfo_d  = ovfo_q;
    unique case (state_q)
      IDLE: if (start) begin
        a_d    = A;
        sgnq_d = A[WIDTH-1] ^ B[WIDTH-1];
        sgnr_d = A[WIDTH-1];
        // Negating the most-negative value yields 2^(WIDTH-1) as unsigned.
        dvd_d  = A[WIDTH-1] ? -A : A;
        divm_d = B[WIDTH-1] ? -B : B;
        rem_d  = '0;
        cnt_d  = '0;
        dz_d   = (B == '0);
        ovf_d  = (A == MOST_NEG) && (B == '1);
        state_d = (B == '0) ? FIX : CALC;
      end
      CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        if (dz_q) begin
          qo_d   = '1;
          ro_d   = a_q;
          dzo_d  = 1'b1;
          ovfo_d = 1'b0;
        end else begin
          // Overflow needs no special case: 2^(WIDTH-1) with a positive
          // sign already encodes as the most-negative pattern.
          qo_d   = sgnq_q ? -dvd_q : dvd_q;
          ro_d   = sgnr_q ? -rem_q : rem_q;
          dzo_d  = 1'b0;
          ovfo_d = ovf_q;
        end
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      divm_q  <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      qo_q    <= '0;
      ro_q    <= '0;
      dzo_q   <= 1'b0;
      ovfo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      divm_q  <= divm_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      qo_q    <= qo_d;
      ro_q    <= ro_d;
      dzo_q   <= dzo_d;
      ovfo_q  <= ovfo_d;
    end
  end

  assign busy = (state_q == CALC) || (state_q == FIX);
  assign done = (state_q == DONE);
  assign Q    = qo_q;
  assign R    = ro_q;
  assign DZ   = dzo_q;
  assign OVF  = ovfo_q;
endmodule

// File: tb/tb_seq_signed_divider.sv
module tb_seq_signed_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] A, B;
  logic         busy, done;
  logic [W-1:0] Q, R;
  logic         DZ, OVF;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Q(Q), .R(R), .DZ(DZ), .OVF(OVF)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: truncating signed division in 64-bit arithmetic; the
  // MIN/-1 quotient 2^31 truncates back to the MIN pattern.
  function automatic void model(input logic [W-1:0] a, b,
                                output logic [W-1:0] q, r,
                                output logic dz, ovf);
    longint sa, sb;
    if (b == '0) begin
      q = '1; r = a; dz = 1'b1; ovf = 1'b0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
      dz = 1'b0;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    end
  endfunction

  // Issue one operation, wait for done (bounded), check everything.
  // inj_at > 0 re-asserts start with 5/1 at that busy cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a, b, input int inj_at);
    logic [W-1:0] eq, er, prev_q;
    logic         edz, eovf;
    int lat, bcnt;
    model(a, b, eq, er, edz, eovf);
    prev_q = Q;
    lat = -1; bcnt = 0;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom;
    for (int n = 1; n <= 100; n++) begin
      if (busy) bcnt++;
      if (done) begin lat = n; break; end
      if (n == 3) chk({tag, "_q_held"}, 64'(Q), 64'(prev_q));
      if (n == inj_at) begin start = 1'b1; A = 5; B = 1; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    if (lat < 0) begin
      chk({tag, "_timeout"}, 64'(0), 64'(1));
    end else begin
      chk({tag, "_lat"},  64'(lat),  64'((b == '0) ? 2 : W + 2));
      chk({tag, "_busy"}, 64'(bcnt), 64'((b == '0) ? 1 : W + 1));
      chk({tag, "_Q"},   64'(Q),   64'(eq));
      chk({tag, "_R"},   64'(R),   64'(er));
      chk({tag, "_DZ"},  64'(DZ),  64'(edz));
      chk({tag, "_OVF"}, 64'(OVF), 64'(eovf));
      @(negedge clk);
      chk({tag, "_done_pulse"}, 64'(done), 64'(0));
      chk({tag, "_Q_hold"},     64'(Q),    64'(eq));
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int sel;
    reset = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_Q",    64'(Q),    64'(0));
    chk("rst_R",    64'(R),    64'(0));
    chk("rst_flags", 64'({DZ, OVF}), 64'(0));
    reset = 1'b0;

    run_op("pos",  32'd100, 32'd7, 0);
    run_op("nega", 32'hFFFF_FF9C, 32'd7, 0);
    run_op("negb", 32'd100, 32'hFFFF_FFF9, 0);
    run_op("dz",   32'd7, 32'd0, 0);
    run_op("ovf",  32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("inj",  32'd100, 32'd7, 10);

    // Reset in the middle of CALC discards the operation.
    @(negedge clk);
    A = 32'd100; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    chk("mid_rst_Q",    64'(Q),    64'(0));
    chk("mid_rst_R",    64'(R),    64'(0));
    run_op("after_rst", 32'd9, 32'd3, 0);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 7);
      ra = $urandom; rb = $urandom;
      case (sel)
        0: rb = '0;
        1: rb = W'($urandom_range(1, 15));
        2: rb = -W'($urandom_range(1, 15));
        3: begin ra = 32'h8000_0000; rb = ($urandom_range(0, 1) != 0) ? '1 : rb; end
        4: ra = W'($urandom_range(0, 20));
        5: rb = 32'h8000_0000;
        default: ;
      endcase
      run_op("rand", ra, rb, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
